// File: rtl/reg_file_pkg.sv
// Shared widths and sequencer state encoding for the general-purpose register file.
package reg_file_pkg;

  localparam int CPU_REGNO_WIDTH = 5;
  localparam int CPU_REG_WIDTH   = 32;
  localparam int CPU_NREGS       = 32;

  typedef logic [CPU_REGNO_WIDTH-1:0] regno_t;
  typedef logic [CPU_REG_WIDTH-1:0]   reg_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_if.sv
// Writeback-to-register-file and register-file-to-decode signal bundle.
interface reg_file_if;
  import reg_file_pkg::*;

  logic   i_exec_stall;
  logic   i_mem_stall;
  logic   i_fetch_stall;
  regno_t i_rs_no;
  regno_t i_rt_no;
  reg_t   o_rs_val;
  reg_t   o_rt_val;
  regno_t i_rd_no;
  reg_t   i_rd_val;
  logic   o_init_busy;

  modport slave (
    input  i_exec_stall, i_mem_stall, i_fetch_stall,
    input  i_rs_no, i_rt_no, i_rd_no, i_rd_val,
    output o_rs_val, o_rt_val, o_init_busy
  );

  modport master (
    output i_exec_stall, i_mem_stall, i_fetch_stall,
    output i_rs_no, i_rt_no, i_rd_no, i_rd_val,
    input  o_rs_val, o_rt_val, o_init_busy
  );

endinterface

// File: rtl/reg_file_rdport.sv
// One registered read port: r0 / writeback-bypass / array select, held while the core stalls.
module reg_file_rdport
  import reg_file_pkg::*;
(
  input  logic   clk,
  input  logic   nrst,
  input  logic   i_run,
  input  logic   i_stall,
  input  regno_t i_idx,
  input  regno_t i_rd_no,
  input  reg_t   i_rd_val,
  input  reg_t   i_arr_val,
  output reg_t   o_val
);

  reg_t w_sel;
  reg_t r_val;

  // NOTE: assign a default first so no path through always_comb leaves w_sel unassigned (latch).
  always_comb begin
    w_sel = i_arr_val;
    if (i_idx == '0)          w_sel = '0;
    else if (i_idx == i_rd_no) w_sel = i_rd_val;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)         r_val <= '0;
    else if (!i_run)   r_val <= '0;
    else if (!i_stall) r_val <= w_sel;
  end

  assign o_val = r_val;

endmodule

// File: rtl/reg_file.sv
// Register file r0..r31 with post-reset clear sequencer and two bypassed, registered read ports.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       nrst,
  reg_file_if.slave bus
);

  rf_state_e r_state;
  regno_t    r_cnt;
  logic      r_init_busy;

  logic   w_run;
  logic   w_core_stall;
  logic   w_we;
  regno_t w_waddr;
  reg_t   w_wdata;
  reg_t   w_rs_arr;
  reg_t   w_rt_arr;

  reg_t r_regs [1:CPU_NREGS-1];

  assign w_run        = (r_state == ST_RUN);
  assign w_core_stall = bus.i_exec_stall | bus.i_mem_stall | bus.i_fetch_stall;

  // The clear sequencer owns the single write port during INIT; writeback owns it in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cnt;
    w_wdata = '0;
    if (!w_run) begin
      w_we = 1'b1;
    end else if (bus.i_rd_no != '0) begin
      w_we    = 1'b1;
      w_waddr = bus.i_rd_no;
      w_wdata = bus.i_rd_val;
    end
  end

  // NOTE: the array has no reset; the clear sequencer zeroes it, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_regs[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_INIT;
      r_cnt       <= regno_t'(1);
      r_init_busy <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == regno_t'(CPU_NREGS - 1)) begin
            r_state     <= ST_RUN;
            r_init_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + regno_t'(1);
          end
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign w_rs_arr = (bus.i_rs_no == '0) ? '0 : r_regs[bus.i_rs_no];
  assign w_rt_arr = (bus.i_rt_no == '0) ? '0 : r_regs[bus.i_rt_no];

  reg_file_rdport u_rs_port (
    .clk       (clk),
    .nrst      (nrst),
    .i_run     (w_run),
    .i_stall   (w_core_stall),
    .i_idx     (bus.i_rs_no),
    .i_rd_no   (bus.i_rd_no),
    .i_rd_val  (bus.i_rd_val),
    .i_arr_val (w_rs_arr),
    .o_val     (bus.o_rs_val)
  );

  reg_file_rdport u_rt_port (
    .clk       (clk),
    .nrst      (nrst),
    .i_run     (w_run),
    .i_stall   (w_core_stall),
    .i_idx     (bus.i_rt_no),
    .i_rd_no   (bus.i_rd_no),
    .i_rd_val  (bus.i_rd_val),
    .i_arr_val (w_rt_arr),
    .o_val     (bus.o_rt_val)
  );

  assign bus.o_init_busy = r_init_busy;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues per-edge expectations, a monitor compares after each edge.
module tb_reg_file;
  import reg_file_pkg::*;

  typedef struct {
    int   tag;
    bit   chk_busy;
    bit   exp_busy;
    bit   chk_val;
    reg_t exp_rs;
    reg_t exp_rt;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  reg_file_if bus ();

  reg_file dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and queues what the outputs must show after the following edge.
  task automatic cycle(input int tag, input regno_t rs, input regno_t rt, input regno_t rd,
                       input reg_t rdv, input logic [2:0] stall, input bit chk_busy,
                       input bit exp_busy, input bit chk_val, input reg_t ers, input reg_t ert);
    exp_t e;
    @(negedge clk);
    bus.i_rs_no       = rs;
    bus.i_rt_no       = rt;
    bus.i_rd_no       = rd;
    bus.i_rd_val      = rdv;
    bus.i_exec_stall  = stall[0];
    bus.i_mem_stall   = stall[1];
    bus.i_fetch_stall = stall[2];
    e.tag = tag; e.chk_busy = chk_busy; e.exp_busy = exp_busy;
    e.chk_val = chk_val; e.exp_rs = ers; e.exp_rt = ert;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic reset_pulse(input int tag);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check($sformatf("rst%0d_busy", tag), 32'(bus.o_init_busy), 32'd1);
    check($sformatf("rst%0d_rs", tag), bus.o_rs_val, 32'd0);
    check($sformatf("rst%0d_rt", tag), bus.o_rt_val, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b1;
    check($sformatf("rst%0d_busy_rel", tag), 32'(bus.o_init_busy), 32'd1);
  endtask

  // Runs n INIT cycles with a writeback attempt to r5; busy must drop only after edge 31.
  task automatic init_cycles(input int tag, input int n);
    for (int k = 1; k <= n; k++)
      cycle(tag * 100 + k, 5'd5, 5'd31, 5'd5, 32'hDEADBEEF, 3'b000, 1'b1, (k != 31), 1'b1, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_busy) check($sformatf("t%0d_busy", e.tag), 32'(bus.o_init_busy), 32'(e.exp_busy));
        if (e.chk_val) begin
          check($sformatf("t%0d_rs", e.tag), bus.o_rs_val, e.exp_rs);
          check($sformatf("t%0d_rt", e.tag), bus.o_rt_val, e.exp_rt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    bus.i_rs_no = '0; bus.i_rt_no = '0; bus.i_rd_no = '0; bus.i_rd_val = '0;
    bus.i_exec_stall = 1'b0; bus.i_mem_stall = 1'b0; bus.i_fetch_stall = 1'b0;

    // Reset clear with an ignored INIT write to r5.
    reset_pulse(1);
    init_cycles(1, 31);
    cycle(200, 5'd5, 5'd31, 5'd0, '0, 3'b000, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);

    // Basic write then read.
    cycle(210, 5'd0, 5'd0, 5'd7, 32'h12345678, 3'b000, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
    cycle(211, 5'd7, 5'd0, 5'd0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'd0);

    // r0 protection.
    cycle(220, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 3'b000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    cycle(221, 5'd0, 5'd0, 5'd0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);

    // Bypass on both ports, then the stored value.
    cycle(230, 5'd0, 5'd0, 5'd3, 32'h00000001, 3'b000, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    cycle(231, 5'd3, 5'd3, 5'd3, 32'hA5A5A5A5, 3'b000, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    cycle(232, 5'd3, 5'd3, 5'd0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5);

    // Mem stall holds outputs while a write to r7 commits.
    cycle(240, 5'd7, 5'd0, 5'd0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'd0);
    for (int i = 0; i < 3; i++)
      cycle(241 + i, 5'd3, 5'd3, 5'd7, 32'h00000000, 3'b010, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'd0);
    cycle(244, 5'd7, 5'd3, 5'd0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 32'd0, 32'hA5A5A5A5);

    // Exec and fetch stalls also hold; port B bypass with port A from the array.
    cycle(250, 5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 3'b000, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);
    cycle(251, 5'd0, 5'd0, 5'd0, '0, 3'b001, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);
    cycle(252, 5'd0, 5'd0, 5'd0, '0, 3'b100, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);
    cycle(253, 5'd9, 5'd12, 5'd12, 32'h000055AA, 3'b000, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h000055AA);

    // Reset mid-RUN, then reset again mid-INIT, then a full clear.
    reset_pulse(2);
    init_cycles(3, 10);
    reset_pulse(3);
    init_cycles(4, 31);
    for (int i = 1; i <= 16; i++)
      cycle(500 + i, regno_t'(i), regno_t'(32 - i), 5'd0, '0, 3'b000, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);

    #3;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file at the far end of the writeback interface: accepts the `rd_no`/`rd_val` pair driven by the writeback stage and serves two registered read ports to decode. Register 0 reads as zero and is never written. After reset, an internal sequencer zero-clears r1..r31 while holding the core stalled, so the storage array needs no per-bit reset. Same-cycle write-to-read bypass keeps decode coherent with writeback.

## Interface
- No module parameters.
- Widths come from the shared header: `CPU_REGNO_WIDTH` (5) and `CPU_REG_WIDTH` (32).
- `clk`  in  1  core clock; all state updates on the rising edge.
- `nrst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_exec_stall`, `i_mem_stall`, `i_fetch_stall`  in  1 each  CU stalls; `core_stall` is their OR.
- `i_rs_no`  in  `CPU_REGNO_WIDTH`  read port A index.
- `i_rt_no`  in  `CPU_REGNO_WIDTH`  read port B index.
- `o_rs_val`  out  `CPU_REG_WIDTH`  read port A data, registered.
- `o_rt_val`  out  `CPU_REG_WIDTH`  read port B data, registered.
- `i_rd_no`  in  `CPU_REGNO_WIDTH`  write index from writeback; 0 means no write.
- `i_rd_val`  in  `CPU_REG_WIDTH`  write data from writeback.
- `o_init_busy`  out  1  high while the clear sequence runs; the CU ORs it into its stall.

## Operation
- Storage: 31 × `CPU_REG_WIDTH` entries for r1..r31. r0 is not stored.
- FSM states:
  - INIT: entered on reset. A 5-bit clear counter starts at 1. Each clock writes 0 to `reg[cnt]` and increments `cnt`. When `cnt`==31 is cleared, the FSM moves to RUN.
  - RUN: normal operation; the FSM stays here until the next reset.
- Write, RUN only: if `i_rd_no`≠0, then `reg[i_rd_no]` ← `i_rd_val` on the clock edge.
  - Writes are not gated by `core_stall`. Writeback holds its outputs during a stall, so a rewrite stores the same value and is harmless.
- Write, INIT: the write port is ignored.
- Read, RUN and `!core_stall`: each output register loads the value selected for its index:
  - index 0 → 0;
  - index == `i_rd_no` and `i_rd_no`≠0 → `i_rd_val` (bypass);
  - otherwise → `reg[index]`.
- Read, RUN and `core_stall`: `o_rs_val`/`o_rt_val` hold.
- Read, INIT: `o_rs_val`/`o_rt_val` load 0 every cycle.
- Both ports may address the same register; both return the same value, including the bypassed value.

## Timing
- Reset values: `o_rs_val`=0, `o_rt_val`=0, `o_init_busy`=1, FSM=INIT, `cnt`=1. Array contents are undefined until cleared.
- Clear duration: exactly 31 rising edges after `nrst` deasserts.
  - Edge k (k = 1..31) clears r_k.
  - `o_init_busy` is registered and reads 0 after edge 31.
- Read latency: 1 cycle. An index presented before edge N appears on the output after edge N, provided `core_stall` is low at edge N.
- Write-to-read:
  - A write and a read of the same index at the same edge produce the new value (bypass).
  - A read at any later edge sees the stored value.
- Reset asserted mid-INIT or mid-RUN: outputs go to reset values immediately and the clear sequence restarts from r1.
- Stall and write at the same edge: the write commits; the read outputs hold.

## Structure
- `CPU_REGNO_WIDTH`, `CPU_REG_WIDTH` and a `CPU_NREGS` (32) constant live in `cpu_common.vh`.
- FSM state encodings live in `cpu_const.vh`.
- One sub-module is natural: `reg_file_rdport`. It holds the index-0 / bypass / array mux and the held output register, and is instantiated twice.
- The array and the clear sequencer stay in `reg_file`.

## Test plan
- Reset clear:
  - Stimulus: pulse `nrst` low, then drive `i_rd_no`=5, `i_rd_val`=0xDEADBEEF during INIT.
  - Required: `o_init_busy` stays 1 for exactly 31 edges. Afterwards, reading r5 returns 0 (the INIT write was ignored) and reading r31 returns 0.
- Basic write/read:
  - Stimulus: write r7=0x12345678, then read `i_rs_no`=7, `i_rt_no`=0 on the next cycle.
  - Required: `o_rs_val`=0x12345678, `o_rt_val`=0.
- r0 protection:
  - Stimulus: `i_rd_no`=0, `i_rd_val`=0xFFFFFFFF, with a simultaneous read of r0 on both ports.
  - Required: both outputs = 0, at that edge and at later edges.
- Bypass:
  - Stimulus: r3 holds 0x1. At the same edge, write r3=0xA5A5A5A5 and read r3 on both ports.
  - Required: both outputs = 0xA5A5A5A5 after that edge.
- Stall hold:
  - Stimulus: read r7 (0x12345678), then raise `i_mem_stall` for 3 cycles while changing `i_rs_no` to 3 and writing r7=0x0.
  - Required: `o_rs_val` holds 0x12345678 during the stall; reading r7 after the stall returns 0x0.
- Reset mid-INIT:
  - Stimulus: deassert `nrst`, wait 10 edges, reassert it, then release.
  - Required: `o_init_busy`=1 for a full 31 edges again, and all registers read 0 afterwards.
